// File: rtl/reaction_round_sequencer_if.sv
// ==== reaction_round_sequencer_if : user strobes in, display/status out ====
// Rev 1.0
`default_nettype none

interface reaction_round_sequencer_if;
   logic        tick_1khz;
   logic        start_pulse;
   logic        stop_pulse;
   logic        recall_pulse;
   logic        stimulus_led;
   logic [2:0]  state_code;
   logic [13:0] time_ms;
   logic        time_valid;
   logic [13:0] best_ms;

   modport master (
      output tick_1khz, start_pulse, stop_pulse, recall_pulse,
      input  stimulus_led, state_code, time_ms, time_valid, best_ms
   );

   modport slave (
      input  tick_1khz, start_pulse, stop_pulse, recall_pulse,
      output stimulus_led, state_code, time_ms, time_valid, best_ms
   );
endinterface

`default_nettype wire

// File: rtl/reaction_round_sequencer.sv
// ==== reaction_round_sequencer : random-delay reaction-time game round FSM ====
// Rev 1.0
`default_nettype none

module reaction_round_sequencer #(
   parameter int MIN_DELAY_MS = 1000,
   parameter int RAND_BITS    = 11,
   parameter int MAX_REACT_MS = 9999
) (
   input  wire logic clk,
   input  wire logic reset,
   reaction_round_sequencer_if.slave bus
);

   localparam int          DLY_W     = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;
   localparam logic [13:0] MAX_CNT   = 14'(MAX_REACT_MS);
   localparam logic [13:0] LAST_CNT  = 14'(MAX_REACT_MS - 1);
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARM        = 3'd1,
      WAIT_REACT = 3'd2,
      RESULT     = 3'd3,
      EARLY      = 3'd4,
      TIMEOUT    = 3'd5,
      RECALL     = 3'd6
   } state_t;

   state_t           state;
   logic [15:0]      lfsr;
   logic             lfsr_fb;
   logic [DLY_W-1:0] delay_cnt;
   logic [DLY_W-1:0] delay_load;
   logic [13:0]      react_cnt;
   logic             stim_led;
   logic [13:0]      disp_ms;
   logic             valid;
   logic [13:0]      best;

   // Taps 16,14,13,11 in right-shift form: bit 0 is the oldest stage.
   assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign delay_load = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_BITS-1:0]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr_fb, lfsr[15:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         delay_cnt <= '0;
         react_cnt <= '0;
         stim_led  <= 1'b0;
         disp_ms   <= '0;
         valid     <= 1'b0;
         best      <= MAX_CNT;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_pulse) begin
                  state     <= ARM;
                  delay_cnt <= delay_load;
                  disp_ms   <= '0;
               end else if (bus.recall_pulse) begin
                  state   <= RECALL;
                  disp_ms <= best;
               end
            end

            ARM: begin
               // A press during the armed delay is a false start, even on a tick.
               if (bus.stop_pulse) begin
                  state   <= EARLY;
                  disp_ms <= '0;
               end else if (bus.tick_1khz) begin
                  if (delay_cnt <= DLY_W'(1)) begin
                     state     <= WAIT_REACT;
                     react_cnt <= '0;
                     stim_led  <= 1'b1;
                     disp_ms   <= '0;
                  end else begin
                     delay_cnt <= delay_cnt - DLY_W'(1);
                  end
               end
            end

            WAIT_REACT: begin
               if (bus.stop_pulse) begin
                  state    <= RESULT;
                  stim_led <= 1'b0;
                  disp_ms  <= react_cnt;
                  valid    <= 1'b1;
                  if (react_cnt < best) begin
                     best <= react_cnt;
                  end
               end else if (bus.tick_1khz) begin
                  if (react_cnt >= LAST_CNT) begin
                     state     <= TIMEOUT;
                     react_cnt <= MAX_CNT;
                     stim_led  <= 1'b0;
                     disp_ms   <= '0;
                  end else begin
                     react_cnt <= react_cnt + 14'd1;
                     disp_ms   <= react_cnt + 14'd1;
                  end
               end
            end

            RESULT, EARLY, TIMEOUT: begin
               if (bus.start_pulse) begin
                  state     <= ARM;
                  delay_cnt <= delay_load;
                  disp_ms   <= '0;
               end else if (bus.recall_pulse) begin
                  state   <= RECALL;
                  disp_ms <= best;
               end
            end

            RECALL: begin
               if (bus.start_pulse) begin
                  state     <= ARM;
                  delay_cnt <= delay_load;
                  disp_ms   <= '0;
               end else if (bus.recall_pulse) begin
                  state   <= IDLE;
                  disp_ms <= '0;
               end
            end

            default: begin
               state    <= IDLE;
               stim_led <= 1'b0;
               disp_ms  <= '0;
            end
         endcase
      end
   end

   assign bus.stimulus_led = stim_led;
   assign bus.state_code   = state;
   assign bus.time_ms      = disp_ms;
   assign bus.time_valid   = valid;
   assign bus.best_ms      = best;

endmodule

`default_nettype wire

// File: tb/tb_reaction_round_sequencer.sv
// ==== tb_reaction_round_sequencer : directed self-checking bench ====
// Rev 1.0
`default_nettype none

module tb_reaction_round_sequencer;

   logic clk    = 1'b0;
   logic reset  = 1'b0;
   logic tick   = 1'b0;
   logic start  = 1'b0;
   logic stop   = 1'b0;
   logic recall = 1'b0;

   int errors  = 0;
   int checks  = 0;
   int valid_a = 0;
   int valid_b = 0;
   logic [1:0]  start_rand = 2'd0;
   logic [15:0] ref_lfsr;

   always #5 clk = ~clk;

   reaction_round_sequencer_if ifa ();
   reaction_round_sequencer_if ifb ();

   assign ifa.tick_1khz    = tick;
   assign ifa.start_pulse  = start;
   assign ifa.stop_pulse   = stop;
   assign ifa.recall_pulse = recall;
   assign ifb.tick_1khz    = tick;
   assign ifb.start_pulse  = start;
   assign ifb.stop_pulse   = stop;
   assign ifb.recall_pulse = recall;

   reaction_round_sequencer #(
      .MIN_DELAY_MS (3),
      .RAND_BITS    (2),
      .MAX_REACT_MS (9999)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   // Short-timeout copy fed the same strobes.
   reaction_round_sequencer #(
      .MIN_DELAY_MS (3),
      .RAND_BITS    (2),
      .MAX_REACT_MS (20)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   always @(posedge clk or negedge reset) begin
      if (!reset) ref_lfsr <= 16'hACE1;
      else        ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
   end

   always @(negedge clk) begin
      if (ifa.time_valid === 1'b1) valid_a++;
      if (ifb.time_valid === 1'b1) valid_b++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // mask = {tick, start, stop, recall}; returns at the negedge after the sampling edge
   task automatic pulse(input logic [3:0] mask);
      @(negedge clk);
      if (mask[2]) start_rand = ref_lfsr[1:0];
      {tick, start, stop, recall} = mask;
      @(negedge clk);
      {tick, start, stop, recall} = 4'b0000;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         pulse(4'b1000);
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic wait_for_led(input string tag);
      int n;
      n = 0;
      while (ifa.stimulus_led !== 1'b1 && n < 10) begin
         ticks(1);
         n++;
      end
      check({tag, "_arm_ticks"}, n, 3 + start_rand);
      check({tag, "_wait_state"}, ifa.state_code, 2);
      check({tag, "_wait_ms"}, ifa.time_ms, 0);
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_state", ifa.state_code, 0);
      check("rst_led", ifa.stimulus_led, 0);
      check("rst_time", ifa.time_ms, 0);
      check("rst_valid", ifa.time_valid, 0);
      check("rst_best", ifa.best_ms, 9999);
      check("rst_best_b", ifb.best_ms, 20);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      pulse(4'b0010);
      check("idle_stop_ignored", ifa.state_code, 0);

      // Round 1: 250 ms reaction; copy B times out at 20
      pulse(4'b0100);
      check("r1_arm", ifa.state_code, 1);
      check("r1_arm_led", ifa.stimulus_led, 0);
      wait_for_led("r1");
      ticks(19);
      check("b_count19", ifb.time_ms, 19);
      check("b_state19", ifb.state_code, 2);
      ticks(1);
      check("b_timeout_state", ifb.state_code, 5);
      check("b_timeout_ms", ifb.time_ms, 0);
      check("b_timeout_led", ifb.stimulus_led, 0);
      ticks(230);
      check("r1_live", ifa.time_ms, 250);
      pulse(4'b0010);
      check("r1_state", ifa.state_code, 3);
      check("r1_time", ifa.time_ms, 250);
      check("r1_valid", ifa.time_valid, 1);
      check("r1_best", ifa.best_ms, 250);
      check("r1_led", ifa.stimulus_led, 0);
      @(negedge clk);
      check("r1_valid_off", ifa.time_valid, 0);
      check("r1_hold", ifa.time_ms, 250);
      check("b_stop_ignored", ifb.state_code, 5);

      // Round 2: 400 ms, best stays 250, then recall
      pulse(4'b0100);
      wait_for_led("r2");
      ticks(200);
      pulse(4'b0100);
      check("wait_start_ignored", ifa.state_code, 2);
      ticks(200);
      check("r2_live", ifa.time_ms, 400);
      pulse(4'b0010);
      check("r2_time", ifa.time_ms, 400);
      check("r2_valid", ifa.time_valid, 1);
      check("r2_best", ifa.best_ms, 250);
      pulse(4'b0001);
      check("recall_state", ifa.state_code, 6);
      check("recall_time", ifa.time_ms, 250);
      pulse(4'b0001);
      check("recall_exit", ifa.state_code, 0);
      check("recall_exit_ms", ifa.time_ms, 0);

      // False start, press coinciding with a tick
      pulse(4'b0100);
      ticks(1);
      check("early_arm", ifa.state_code, 1);
      pulse(4'b1010);
      check("early_state", ifa.state_code, 4);
      ticks(8);
      check("early_hold", ifa.state_code, 4);
      check("early_led", ifa.stimulus_led, 0);
      check("early_best", ifa.best_ms, 250);

      // Start wins over recall; stop with same-cycle tick at 57
      pulse(4'b0101);
      check("start_wins", ifa.state_code, 1);
      wait_for_led("r3");
      ticks(57);
      pulse(4'b1010);
      check("r3_state", ifa.state_code, 3);
      check("r3_time", ifa.time_ms, 57);
      check("r3_best", ifa.best_ms, 57);

      // Reset in the middle of a round
      pulse(4'b0100);
      wait_for_led("r4");
      ticks(30);
      check("r4_live", ifa.time_ms, 30);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_state", ifa.state_code, 0);
      check("mid_rst_led", ifa.stimulus_led, 0);
      check("mid_rst_time", ifa.time_ms, 0);
      check("mid_rst_valid", ifa.time_valid, 0);
      check("mid_rst_best", ifa.best_ms, 9999);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_state", ifa.state_code, 0);
      check("post_rst_best", ifa.best_ms, 9999);
      check("post_rst_valid_cnt", valid_a, 3);
      check("b_never_valid", valid_b, 0);
      check("b_best_unchanged", ifb.best_ms, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reaction_round_sequencer.md
REACTION_ROUND_SEQUENCER -- requirements
Module: reaction_round_sequencer

Interface
REQ-001 SHALL have parameter MIN_DELAY_MS, default 1000: minimum armed delay before stimulus, in ms ticks.
REQ-002 SHALL have parameter RAND_BITS, default 11: width of random delay addend (0..2^RAND_BITS-1 ms).
REQ-003 SHALL have parameter MAX_REACT_MS, default 9999: reaction count at which the round times out.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 tick_1khz  input  1  one-clk-wide 1 kHz strobe; sole timebase for all ms counting.
REQ-007 start_pulse  input  1  one-clk debounced start request.
REQ-008 stop_pulse  input  1  one-clk debounced reaction press.
REQ-009 recall_pulse  input  1  one-clk debounced best-time recall request.
REQ-010 stimulus_led  output  1  high while user must react.
REQ-011 state_code  output  3  current state: IDLE=0, ARM=1, WAIT_REACT=2, RESULT=3, EARLY=4, TIMEOUT=5, RECALL=6.
REQ-012 time_ms  output  14  displayed value: last result in RESULT, best in RECALL, live count in WAIT_REACT, else 0.
REQ-013 time_valid  output  1  one-clk pulse when a new valid result is latched.
REQ-014 best_ms  output  14  lowest valid result since reset.

Function
REQ-015 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clk in all states; seed 16'hACE1.
REQ-016 IDLE: start_pulse -> ARM; delay counter loaded with MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
REQ-017 ARM: each tick_1khz decrements delay counter; tick with counter==1 -> WAIT_REACT, reaction counter cleared to 0.
REQ-018 ARM: stop_pulse -> EARLY (penalty), regardless of simultaneous tick; no result latched.
REQ-019 stimulus_led SHALL be registered and high exactly while state is WAIT_REACT (rises 1 clk after the terminal ARM tick).
REQ-020 WAIT_REACT: each tick_1khz increments reaction counter; stop_pulse -> RESULT, latching counter value as-is (a same-cycle tick is not added).
REQ-021 WAIT_REACT: tick with counter==MAX_REACT_MS-1 -> TIMEOUT; counter never exceeds MAX_REACT_MS.
REQ-022 On entry to RESULT, time_valid SHALL pulse for exactly 1 clk, coincident with latched value on time_ms.
REQ-023 best_ms SHALL update to latched result when result < best_ms, same clk as time_valid; EARLY/TIMEOUT never update it.
REQ-024 RESULT, EARLY, TIMEOUT: start_pulse -> ARM (new round, new delay); recall_pulse -> RECALL.
REQ-025 IDLE: recall_pulse -> RECALL.
REQ-026 RECALL: time_ms = best_ms; start_pulse -> ARM; recall_pulse -> IDLE.
REQ-027 start_pulse and recall_pulse SHALL be ignored in ARM and WAIT_REACT; stop_pulse ignored in IDLE, RESULT, EARLY, TIMEOUT, RECALL.
REQ-028 Simultaneous start_pulse and recall_pulse in a state accepting both: start_pulse wins.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 reset low SHALL immediately force state IDLE, stimulus_led 0, time_ms 0, time_valid 0, best_ms MAX_REACT_MS, counters 0, LFSR 16'hACE1.
REQ-031 Reset asserted mid-round SHALL abort the round without latching any result or altering best_ms after release.

Verification
REQ-032 MIN_DELAY_MS=3, RAND_BITS=2: start, ticks every 10 clk -> stimulus_led rises after 3..6 ticks, matching value predicted by a reference LFSR model.
REQ-033 In WAIT_REACT, 250 ticks then stop_pulse -> RESULT, time_ms=250, time_valid one clk, best_ms=250.
REQ-034 Second round result 400 -> time_ms=400, best_ms stays 250; recall_pulse -> state 6, time_ms=250.
REQ-035 stop_pulse during ARM -> state 4, stimulus_led never rises, best_ms unchanged.
REQ-036 MAX_REACT_MS=20, no stop -> after 20 ticks state 5, counter stays 20, time_valid never pulses.
REQ-037 stop_pulse and tick same clk at count 57 -> time_ms=57; reset low mid-WAIT_REACT -> all REQ-030 values, best_ms retains no partial result.
